// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller FSM states and default LFSR/MISR constants.
// Pure declarations; no logic, no timing.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } bist_state_e;

    localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;
    localparam logic [7:0] DEF_LFSR_SEED = 8'h01;
    localparam logic [3:0] DEF_MISR_POLY = 4'h9;

endpackage

// File: rtl/bist_shift_reg.sv
// Shift register with parity feedback over MASK taps; a nonzero xor_i folds a response in (MISR use).
// Registered one-cycle update; shift_val_o is the combinational value the next shift would load.
module bist_shift_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MASK    = '1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] xor_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] shift_val_o
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;
    logic [WIDTH-1:0] shift_val;

    always_comb begin
        shift_val = {val_q[WIDTH-2:0], ^(val_q & MASK)} ^ xor_i;
        val_d     = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (shift_i) begin
            val_d = shift_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q <= RST_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o         = val_q;
    assign shift_val_o = shift_val;

endmodule

// File: rtl/bist_controller.sv
// LFSR-driven BIST session controller with MISR response compaction and golden-signature compare.
// start->done is NUM_PATTERNS+2 cycles; pause freezes the session in RUN, adding one cycle per paused cycle.
module bist_controller
    import bist_pkg::*;
#(
    parameter int unsigned      PAT_W        = 8,
    parameter int unsigned      RSP_W        = 4,
    parameter logic [PAT_W-1:0] LFSR_TAPS    = PAT_W'(DEF_LFSR_TAPS),
    parameter logic [PAT_W-1:0] LFSR_SEED    = PAT_W'(DEF_LFSR_SEED),
    parameter logic [RSP_W-1:0] MISR_POLY    = RSP_W'(DEF_MISR_POLY),
    parameter int unsigned      NUM_PATTERNS = 255,
    parameter logic [RSP_W-1:0] GOLDEN       = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                pause,
    output logic [PAT_W-1:0]                    cut_pattern,
    input  logic [RSP_W-1:0]                    cut_response,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [RSP_W-1:0]                    signature,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]   pattern_count
);

    localparam int unsigned      CNT_W      = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_PATTERNS - 1);

    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("bist_controller: LFSR_SEED must be nonzero");
    end
    if (NUM_PATTERNS == 0) begin : g_bad_count
        $error("bist_controller: NUM_PATTERNS must be at least 1");
    end
    if (PAT_W < 2 || PAT_W > 32 || RSP_W < 2 || RSP_W > 32) begin : g_bad_width
        $error("bist_controller: PAT_W and RSP_W must be within 2..32");
    end

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pass_q, pass_d;
    logic             seed_load;
    logic             run_step;
    logic [RSP_W-1:0] misr_next;
    logic [PAT_W-1:0] lfsr_next_unused;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pass_d    = pass_q;
        seed_load = 1'b0;
        run_step  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SEED;
            end
            ST_SEED: begin
                seed_load = 1'b1;
                count_d   = '0;
                pass_d    = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (!pause) begin
                    run_step = 1'b1;
                    count_d  = count_q + CNT_W'(1);
                    // Verdict is taken from the MISR value being written on the final edge.
                    if (count_q == LAST_COUNT) begin
                        state_d = ST_DONE;
                        pass_d  = (misr_next == GOLDEN);
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_SEED;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    bist_shift_reg #(
        .WIDTH   (PAT_W),
        .MASK    (LFSR_TAPS),
        .RST_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (seed_load),
        .load_val_i  (LFSR_SEED),
        .shift_i     (run_step),
        .xor_i       ({PAT_W{1'b0}}),
        .q_o         (cut_pattern),
        .shift_val_o (lfsr_next_unused)
    );

    bist_shift_reg #(
        .WIDTH   (RSP_W),
        .MASK    (MISR_POLY),
        .RST_VAL ({RSP_W{1'b0}})
    ) u_misr (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (seed_load),
        .load_val_i  ({RSP_W{1'b0}}),
        .shift_i     (run_step),
        .xor_i       (cut_response),
        .q_o         (signature),
        .shift_val_o (misr_next)
    );

    assign busy          = (state_q == ST_SEED) || (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign pass          = pass_q;
    assign pattern_count = count_q;

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 SHALL have parameter PAT_W, default 8: LFSR/pattern width, legal range 2..32.
REQ-002 SHALL have parameter RSP_W, default 4: MISR/response width, legal range 2..32.
REQ-003 SHALL have parameter LFSR_TAPS, default 8'hB8: feedback tap mask, PAT_W bits.
REQ-004 SHALL have parameter LFSR_SEED, default 8'h01: LFSR start value, PAT_W bits, nonzero.
REQ-005 SHALL have parameter MISR_POLY, default 4'h9: MISR feedback mask, RSP_W bits.
REQ-006 SHALL have parameter NUM_PATTERNS, default 255: patterns per session, legal range 1..2^PAT_W-1.
REQ-007 SHALL have parameter GOLDEN, default 4'h0: expected signature, RSP_W bits.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port start, input, 1 bit: session request.
REQ-011 SHALL have port pause, input, 1 bit: freeze LFSR, MISR and counter while in RUN.
REQ-012 SHALL have port cut_pattern, output, PAT_W bits: current LFSR state driven to the CUT.
REQ-013 SHALL have port cut_response, input, RSP_W bits: combinational CUT response to cut_pattern.
REQ-014 SHALL have port busy, output, 1 bit: high in SEED and RUN.
REQ-015 SHALL have port done, output, 1 bit: high in DONE.
REQ-016 SHALL have port pass, output, 1 bit: signature equals GOLDEN; valid only while done=1.
REQ-017 SHALL have port signature, output, RSP_W bits: current MISR state.
REQ-018 SHALL have port pattern_count, output, $clog2(NUM_PATTERNS+1) bits: patterns compressed so far.

Function
REQ-019 SHALL implement FSM states IDLE, SEED, RUN, DONE.
REQ-020 SHALL transition IDLE->SEED on start=1; start SHALL be ignored in SEED and RUN.
REQ-021 SHALL, in SEED, load LFSR=LFSR_SEED, MISR=0 and pattern_count=0, then go to RUN the next cycle.
REQ-022 SHALL, in each RUN cycle with pause=0, do: LFSR <= {LFSR[PAT_W-2:0], ^(LFSR & LFSR_TAPS)}; MISR <= {MISR[RSP_W-2:0], ^(MISR & MISR_POLY)} ^ cut_response; pattern_count += 1.
REQ-023 SHALL, in RUN with pause=1, hold LFSR, MISR and pattern_count unchanged.
REQ-024 SHALL transition RUN->DONE on the edge where pattern_count reaches NUM_PATTERNS.
REQ-025 SHALL register pass=(MISR_next==GOLDEN) on that same edge, so pass and done rise together.
REQ-026 SHALL hold LFSR, MISR, pass and pattern_count stable in DONE.
REQ-027 SHALL restart with DONE->SEED on start=1; start=0 SHALL hold DONE indefinitely.
REQ-028 SHALL have latency start->done of NUM_PATTERNS+2 cycles with pause never asserted.
REQ-029 SHALL ignore pause outside RUN.
REQ-030 SHALL keep pass=0 whenever done=0.

Reset
REQ-031 SHALL, on rst=1 at an edge, set state=IDLE, LFSR=LFSR_SEED, MISR=0, pattern_count=0, pass=0, busy=0, done=0; rst SHALL override start and pause.
REQ-032 SHALL, on rst mid-session, abandon the session with no partial result retained.

Structure
REQ-033 SHALL place the FSM state enum and default LFSR_TAPS, LFSR_SEED and MISR_POLY constants in shared package bist_pkg.
REQ-034 SHALL reuse one generic sub-module, bist_shift_reg (WIDTH, MASK parameters, optional parallel XOR input), instantiated once as the LFSR and once as the MISR.
REQ-035 SHALL flag LFSR_SEED=0 or NUM_PATTERNS=0 as an elaboration error.

Verification
REQ-036 SHALL cover: defaults, start pulse, cut_response tied 0 -> cut_pattern 01,02,04,08,11,23...; done at cycle 257; signature=0; pass=1.
REQ-037 SHALL cover: cut = 4-bit adder of pattern[7:4]+pattern[3:0], GOLDEN from reference model -> pass=1; one adder output bit stuck-at-0 -> pass=0.
REQ-038 SHALL cover: pause held 10 cycles mid-RUN -> cut_pattern, signature and pattern_count frozen; done at cycle 267.
REQ-039 SHALL cover: rst asserted at pattern_count=100 -> next cycle IDLE with all outputs at reset values; new start -> full session, same signature as an uninterrupted run.
REQ-040 SHALL cover: NUM_PATTERNS=1 -> done 3 cycles after start; start during RUN ignored; start in DONE -> busy=1 on the next cycle and identical signature.
